// File: rtl/prep_scheduler.sv
// Dirty-slot scheduler for the shared trig/rotate pre-processor. Recomputes dirty shape
// slots round-robin, only while the vertical-blank window is open.
module prep_scheduler #(
    parameter int unsigned MAXSHP = 16,
    parameter int unsigned IDW    = $clog2(MAXSHP),
    parameter int unsigned LAT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mark_valid,
    input  logic [IDW-1:0]    mark_id,
    input  logic              mark_all,
    input  logic              endframe,
    input  logic              newframe,
    output logic              ld_en,
    output logic [IDW-1:0]    ld_id,
    output logic              wb_en,
    output logic [IDW-1:0]    wb_id,
    output logic              busy,
    output logic [MAXSHP-1:0] dirty,
    output logic              overrun
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

    state_e            state_q, state_d;
    logic              win_q, win_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    ld_id_q, ld_id_d;
    logic [IDW-1:0]    wb_id_q, wb_id_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [MAXSHP-1:0] dirty_q, dirty_d;
    logic [MAXSHP-1:0] others;
    logic [MAXSHP-1:0] remaining;
    logic [IDW-1:0]    rr_next;

    // First set bit of vec, scanning upward from start and wrapping at MAXSHP.
    function automatic logic [IDW-1:0] pick(input logic [MAXSHP-1:0] vec,
                                            input logic [IDW-1:0]    start);
        logic [IDW-1:0] res;
        logic [IDW-1:0] idx;
        logic           found;
        res   = start;
        found = 1'b0;
        for (int unsigned k = 0; k < MAXSHP; k++) begin
            idx = IDW'((32'(start) + k) % MAXSHP);
            if (!found && vec[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        others          = dirty_q;
        others[ld_id_q] = 1'b0;
        rr_next         = (ld_id_q == IDW'(MAXSHP - 1)) ? '0 : ld_id_q + 1'b1;
        remaining       = (state_q == StWb) ? others : dirty_q;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        ld_id_d = ld_id_q;
        wb_id_d = wb_id_q;
        wait_d  = wait_q;
        dirty_d = dirty_q;
        win_d   = newframe ? 1'b0 : (endframe ? 1'b1 : win_q);

        case (state_q)
            StIdle: begin
                if ((win_q || endframe) && !newframe && (|dirty_q)) begin
                    state_d = StIssue;
                    ld_id_d = pick(dirty_q, rr_q);
                end
            end
            StIssue: begin
                wait_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == CW'(LAT - 1)) begin
                    state_d = StWb;
                    wb_id_d = ld_id_q;
                end
            end
            StWb: begin
                dirty_d[ld_id_q] = 1'b0;
                rr_d             = rr_next;
                // Chain straight into the next slot so there is no idle gap cycle.
                if (win_q && !newframe && (|others)) begin
                    state_d = StIssue;
                    ld_id_d = pick(others, rr_next);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Marks land after the write-back clear so a same-cycle mark wins.
        if (mark_all) begin
            dirty_d = '1;
        end
        for (int unsigned i = 0; i < MAXSHP; i++) begin
            if (mark_valid && (mark_id == IDW'(i))) begin
                dirty_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            win_q   <= 1'b0;
            rr_q    <= '0;
            ld_id_q <= '0;
            wb_id_q <= '0;
            wait_q  <= '0;
            dirty_q <= '1;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            ld_id_q <= ld_id_d;
            wb_id_q <= wb_id_d;
            wait_q  <= wait_d;
            dirty_q <= dirty_d;
        end
    end

    always_comb begin
        ld_en   = (state_q == StIssue);
        wb_en   = (state_q == StWb);
        busy    = (state_q != StIdle);
        ld_id   = ld_id_q;
        wb_id   = wb_id_q;
        dirty   = dirty_q;
        overrun = newframe && ((|remaining) || (state_q == StIssue) || (state_q == StWait));
    end

endmodule

// File: tb/tb_prep_scheduler.sv
// Bench for prep_scheduler: directed scenarios with literal expectations, then random
// marks/window pulses checked every cycle against an operation-age reference model.
module tb_prep_scheduler;

    localparam int unsigned MAXSHP = 16;
    localparam int unsigned IDW    = 4;
    localparam int unsigned LAT    = 4;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              mark_valid = 1'b0;
    logic [IDW-1:0]    mark_id    = '0;
    logic              mark_all   = 1'b0;
    logic              endframe   = 1'b0;
    logic              newframe   = 1'b0;
    logic              ld_en;
    logic [IDW-1:0]    ld_id;
    logic              wb_en;
    logic [IDW-1:0]    wb_id;
    logic              busy;
    logic [MAXSHP-1:0] dirty;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    prep_scheduler #(
        .MAXSHP(MAXSHP),
        .IDW   (IDW),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mark_valid(mark_valid),
        .mark_id   (mark_id),
        .mark_all  (mark_all),
        .endframe  (endframe),
        .newframe  (newframe),
        .ld_en     (ld_en),
        .ld_id     (ld_id),
        .wb_en     (wb_en),
        .wb_id     (wb_id),
        .busy      (busy),
        .dirty     (dirty),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation is a slot plus its age (0 = load cycle, LAT+1 = write-back).
    logic [MAXSHP-1:0] m_dirty;
    bit                m_win;
    bit                m_act;
    int                m_age;
    int                m_slot;
    int                m_rr;
    int                m_ld;
    int                m_wbid;

    function automatic int first_set(input logic [MAXSHP-1:0] v, input int start);
        for (int k = 0; k < int'(MAXSHP); k++) begin
            if (v[(start + k) % MAXSHP]) return (start + k) % MAXSHP;
        end
        return start;
    endfunction

    always @(negedge clk) begin : model
        logic [MAXSHP-1:0] clr, nd, oth;
        logic              e_ld, e_wb, e_ovr;
        if (!rst_n) begin
            m_dirty = '1;
            m_win   = 0;
            m_act   = 0;
            m_age   = 0;
            m_slot  = 0;
            m_rr    = 0;
            m_ld    = 0;
            m_wbid  = 0;
            check("reset_state", 64'({ld_en, wb_en, busy, overrun, ld_id, wb_id, dirty}),
                  64'({4'b0, 4'd0, 4'd0, 16'hffff}));
        end else begin
            e_wb = m_act && (m_age == LAT + 1);
            e_ld = m_act && (m_age == 0);
            clr  = '0;
            if (e_wb) clr[m_slot] = 1'b1;
            e_ovr = newframe && (((m_dirty & ~clr) != '0) || (m_act && m_age <= LAT));
            check("ctl", 64'({ld_en, wb_en, busy, overrun}), 64'({e_ld, e_wb, m_act, e_ovr}));
            check("ids", 64'({ld_id, wb_id}), 64'({IDW'(m_ld), IDW'(m_wbid)}));
            check("dirty", 64'(dirty), 64'(m_dirty));

            nd = m_dirty & ~clr;
            if (mark_all) nd = '1;
            if (mark_valid) nd[mark_id] = 1'b1;

            if (!m_act) begin
                if ((m_win || endframe) && !newframe && m_dirty != '0) begin
                    m_act  = 1;
                    m_age  = 0;
                    m_slot = first_set(m_dirty, m_rr);
                    m_ld   = m_slot;
                end
            end else if (m_age < LAT + 1) begin
                m_age++;
                if (m_age == LAT + 1) m_wbid = m_slot;
            end else begin
                m_rr = (m_slot + 1) % MAXSHP;
                oth  = m_dirty & ~clr;
                if (m_win && !newframe && oth != '0) begin
                    m_slot = first_set(oth, m_rr);
                    m_age  = 0;
                    m_ld   = m_slot;
                end else begin
                    m_act = 0;
                end
            end
            m_win   = newframe ? 0 : (endframe ? 1 : m_win);
            m_dirty = nd;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_end;
        endframe = 1'b1;
        tick;
        endframe = 1'b0;
    endtask

    task automatic pulse_new;
        newframe = 1'b1;
        tick;
        newframe = 1'b0;
    endtask

    task automatic mark(input int id);
        mark_valid = 1'b1;
        mark_id    = IDW'(id);
        tick;
        mark_valid = 1'b0;
    endtask

    task automatic do_reset;
        endframe   = 1'b0;
        newframe   = 1'b0;
        mark_valid = 1'b0;
        mark_all   = 1'b0;
        rst_n      = 1'b0;
        tick;
        rst_n      = 1'b1;
    endtask

    initial begin
        int nwb;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;

        // Full recompute after reset: slots 0..15, one write-back every LAT+2 cycles.
        pulse_end;
        check("t1_first_ld", 64'({ld_en, ld_id}), 64'({1'b1, 4'd0}));
        nwb = 0;
        for (int i = 1; i <= 96; i++) begin
            if (wb_en) begin
                check("t1_wb_id", 64'(wb_id), 64'(nwb));
                check("t1_wb_cycle", 64'(i), 64'(6 * (nwb + 1)));
                nwb++;
            end
            tick;
        end
        check("t1_wb_count", 64'(nwb), 64'd16);
        check("t1_all_clean", 64'({busy, dirty}), 64'd0);
        newframe = 1'b1;
        #1;
        check("t1_no_overrun", 64'(overrun), 64'd0);
        tick;
        newframe = 1'b0;

        // Re-mark during own write-back: bit survives and slot is serviced again.
        mark(7);
        pulse_end;
        repeat (5) tick;
        check("t3_wb", 64'({wb_en, wb_id}), 64'({1'b1, 4'd7}));
        mark(7);
        check("t3_dirty_kept", 64'(dirty), 64'h0080);
        check("t3_idle_gap", 64'(busy), 64'd0);
        tick;
        check("t3_reissue", 64'({ld_en, ld_id}), 64'({1'b1, 4'd7}));
        repeat (6) tick;
        check("t3_done", 64'({busy, dirty}), 64'd0);
        pulse_new;

        // rr becomes 5 after servicing slot 4; then {3,9} -> 9 first, 3 second, rr ends at 4.
        mark(4);
        pulse_end;
        repeat (8) tick;
        pulse_new;
        mark(3);
        mark(9);
        pulse_end;
        check("t2_first_ld", 64'({ld_en, ld_id}), 64'({1'b1, 4'd9}));
        repeat (5) tick;
        check("t2_first_wb", 64'({wb_en, wb_id}), 64'({1'b1, 4'd9}));
        tick;
        check("t2_second_ld", 64'({ld_en, ld_id}), 64'({1'b1, 4'd3}));
        repeat (5) tick;
        check("t2_second_wb", 64'({wb_en, wb_id}), 64'({1'b1, 4'd3}));
        pulse_new;
        mark(2);
        mark(5);
        pulse_end;
        check("t2_rr_end", 64'({ld_en, ld_id}), 64'({1'b1, 4'd5}));
        repeat (14) tick;
        pulse_new;

        // Window too short: 3 done, 4th completes after newframe, 12 wait for next window.
        mark_all = 1'b1;
        tick;
        mark_all = 1'b0;
        pulse_end;
        nwb = 0;
        for (int i = 0; i < 19; i++) begin
            if (wb_en) nwb++;
            tick;
        end
        check("t4_wb_in_window", 64'(nwb), 64'd3);
        newframe = 1'b1;
        #1;
        check("t4_overrun", 64'(overrun), 64'd1);
        tick;
        newframe = 1'b0;
        nwb = 0;
        for (int i = 0; i < 10; i++) begin
            if (wb_en) nwb++;
            tick;
        end
        check("t4_inflight_done", 64'(nwb), 64'd1);
        check("t4_remaining", 64'({busy, 32'($countones(dirty))}), 64'd12);
        pulse_end;
        repeat (80) tick;
        check("t4_resume_clean", 64'({busy, dirty}), 64'd0);
        pulse_new;

        // endframe and newframe together: window never opens.
        mark_all = 1'b1;
        tick;
        mark_all = 1'b0;
        endframe = 1'b1;
        newframe = 1'b1;
        #1;
        check("t5_overrun", 64'(overrun), 64'd1);
        tick;
        endframe = 1'b0;
        newframe = 1'b0;
        check("t5_no_issue_a", 64'({ld_en, busy}), 64'd0);
        tick;
        check("t5_no_issue_b", 64'({ld_en, busy}), 64'd0);

        // Reset mid-WAIT.
        pulse_end;
        repeat (2) tick;
        check("t6_in_wait", 64'({busy, ld_en, wb_en}), 64'({1'b1, 1'b0, 1'b0}));
        rst_n = 1'b0;
        #1;
        check("t6_reset_now", 64'({ld_en, wb_en, busy, overrun, ld_id, wb_id, dirty}),
              64'({4'b0, 4'd0, 4'd0, 16'hffff}));
        tick;
        rst_n = 1'b1;
        nwb = 0;
        for (int i = 0; i < 12; i++) begin
            if (wb_en || ld_en) nwb++;
            tick;
        end
        check("t6_no_op_after", 64'(nwb), 64'd0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset;
            end else begin
                endframe   = ($urandom_range(0, 49) == 0);
                newframe   = ($urandom_range(0, 49) == 0);
                mark_valid = ($urandom_range(0, 2) == 0);
                mark_id    = IDW'($urandom_range(0, MAXSHP - 1));
                mark_all   = ($urandom_range(0, 149) == 0);
                tick;
            end
        end
        endframe   = 1'b0;
        newframe   = 1'b0;
        mark_valid = 1'b0;
        mark_all   = 1'b0;
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
